// File: rtl/gshare_pkg.sv
// Shared types for the gshare predictor: 2-bit direction counter encoding and its
// saturating update rule.
package gshare_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // Saturating step; never wraps past SNT or ST.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    unique case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gshare_predictor_pht_array.sv
// Pattern history table: 2**IDX_W direction counters, one async read port and one
// read-modify-write training port that applies the saturating update in place.
module pht_array #(
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [IDX_W-1:0] raddr,
  output logic [1:0]       rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic             wtaken
);
  import gshare_pkg::*;

  localparam int DEPTH = 1 << IDX_W;

  ctr_t ctr_q [DEPTH];
  ctr_t ctr_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ctr_d[i] = ctr_q[i];
      if (we && waddr == IDX_W'(i)) ctr_d[i] = ctr_next(ctr_q[i], wtaken);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RESET;
    end else begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= ctr_d[i];
    end
  end

  assign rdata = ctr_q[raddr];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PHT indexed by PC ^ GHR, with GHR repair on mispredict.
// Define GSHARE_TRAIN_FWD_EN to forward a same-index training update into the prediction.
module gshare_predictor #(
  parameter int HIST_W = 7
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              predict_valid,
  input  logic [HIST_W-1:0] predict_pc,
  output logic              predict_taken,
  output logic [HIST_W-1:0] predict_history,
  input  logic              train_valid,
  input  logic              train_taken,
  input  logic              train_mispredicted,
  input  logic [HIST_W-1:0] train_history,
  input  logic [HIST_W-1:0] train_pc
);
  import gshare_pkg::*;

  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [HIST_W-1:0] idx_p, idx_t;
  logic [1:0]        rd_ctr;
  ctr_t              pred_ctr;

  assign idx_p = predict_pc ^ ghr_q;
  assign idx_t = train_pc ^ train_history;

  pht_array #(.IDX_W(HIST_W)) u_pht (
    .clk     (clk),
    .areset_n(areset_n),
    .raddr   (idx_p),
    .rdata   (rd_ctr),
    .we      (train_valid),
    .waddr   (idx_t),
    .wtaken  (train_taken)
  );

  always_comb begin
    pred_ctr = ctr_t'(rd_ctr);
`ifdef GSHARE_TRAIN_FWD_EN
    // Same entry read and written: rd_ctr is the pre-update value of PHT[idx_t].
    if (train_valid && idx_p == idx_t) pred_ctr = ctr_next(ctr_t'(rd_ctr), train_taken);
`endif
  end

  // Gate with reset so a forwarded train cannot leak a taken prediction while held in reset.
  assign predict_taken   = areset_n & pred_ctr[1];
  assign predict_history = ghr_q;

  // Mispredict recovery beats speculative shift: the fetch that predicted is being flushed.
  always_comb begin
    ghr_d = ghr_q;
    if (train_valid && train_mispredicted)
      ghr_d = {train_history[HIST_W-2:0], train_taken};
    else if (predict_valid)
      ghr_d = {ghr_q[HIST_W-2:0], predict_taken};
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) ghr_q <= '0;
    else           ghr_q <= ghr_d;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: HIST_W=7 and HIST_W=4 instances share stimulus and are
// checked each cycle against a reference model through a scoreboard queue.
module tb_gshare_predictor;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       pv, tv, tt, tm;
  logic [6:0] ppc, th, tpc;
  logic       pt7, pt4;
  logic [6:0] ph7;
  logic [3:0] ph4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    k;
    logic  tk;
    int    hist;
    string name;
  } exp_t;
  exp_t sbq[$];

  int   m_pht [2][128];
  int   m_ghr [2];
  logic obs_t [2];
  int   obs_h [2];

  always #5 clk = ~clk;

  gshare_predictor #(.HIST_W(7)) dut (
    .clk(clk), .areset_n(areset_n),
    .predict_valid(pv), .predict_pc(ppc),
    .predict_taken(pt7), .predict_history(ph7),
    .train_valid(tv), .train_taken(tt), .train_mispredicted(tm),
    .train_history(th), .train_pc(tpc)
  );

  gshare_predictor #(.HIST_W(4)) dut4 (
    .clk(clk), .areset_n(areset_n),
    .predict_valid(pv), .predict_pc(ppc[3:0]),
    .predict_taken(pt4), .predict_history(ph4),
    .train_valid(tv), .train_taken(tt), .train_mispredicted(tm),
    .train_history(th[3:0]), .train_pc(tpc[3:0])
  );

  function automatic int msk(int k);
    return (k == 0) ? 127 : 15;
  endfunction

  function automatic int f_next(int c, logic t);
    if (t && c < 3) return c + 1;
    if (!t && c > 0) return c - 1;
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ghr[k] = 0;
      for (int i = 0; i < 128; i++) m_pht[k][i] = 1;
    end
  endtask

  // Drive one cycle, score predictions before the edge, advance the model at the edge.
  task automatic step(input logic pv_i, input logic [6:0] ppc_i, input logic tv_i,
                      input logic tt_i, input logic tm_i, input logic [6:0] th_i,
                      input logic [6:0] tpc_i, input string name);
    logic tk [2];
    int   it [2];
    int   m, ip, c, ah;
    logic at;
    exp_t e;
    pv = pv_i; ppc = ppc_i; tv = tv_i; tt = tt_i; tm = tm_i; th = th_i; tpc = tpc_i;
    #1;
    for (int k = 0; k < 2; k++) begin
      m     = msk(k);
      ip    = (int'(ppc_i) & m) ^ m_ghr[k];
      it[k] = int'(tpc_i ^ th_i) & m;
      c     = m_pht[k][ip];
`ifdef GSHARE_TRAIN_FWD_EN
      if (tv_i && ip == it[k]) c = f_next(m_pht[k][it[k]], tt_i);
`endif
      tk[k]  = areset_n && (c >= 2);
      e.k    = k;
      e.tk   = tk[k];
      e.hist = m_ghr[k];
      e.name = name;
      sbq.push_back(e);
    end
    while (sbq.size() > 0) begin
      e  = sbq.pop_front();
      at = (e.k == 0) ? pt7 : pt4;
      ah = (e.k == 0) ? int'(ph7) : int'(ph4);
      checks += 2;
      if (at !== e.tk) begin
        errors++;
        $display("FAIL %s w%0d predict_taken got %0b want %0b", e.name, (e.k == 0) ? 7 : 4, at, e.tk);
      end
      if (ah !== e.hist) begin
        errors++;
        $display("FAIL %s w%0d predict_history got %0h want %0h", e.name, (e.k == 0) ? 7 : 4, ah, e.hist);
      end
      obs_t[e.k] = at;
      obs_h[e.k] = ah;
    end
    @(posedge clk);
    if (areset_n) begin
      for (int k = 0; k < 2; k++) begin
        m = msk(k);
        if (tv_i) m_pht[k][it[k]] = f_next(m_pht[k][it[k]], tt_i);
        if (tv_i && tm_i)  m_ghr[k] = ((int'(th_i) << 1) | int'(tt_i)) & m;
        else if (pv_i)     m_ghr[k] = ((m_ghr[k] << 1) | int'(tk[k])) & m;
      end
    end
    @(negedge clk);
  endtask

  task automatic peek(input logic [6:0] pc, input string name);
    step(1'b0, pc, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, name);
  endtask

  task automatic train(input logic [6:0] pc, input logic [6:0] hist, input logic taken,
                       input logic mis, input string name);
    step(1'b0, 7'h00, 1'b1, taken, mis, hist, pc, name);
  endtask

  task automatic test_reset();
    step(1'b1, 7'h11, 1'b1, 1'b1, 1'b1, 7'h3C, 7'h2D, "in_reset");
    areset_n = 1'b1;
    step(1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, "first_predict");
    checks++;
    if (obs_t[0] !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b want 0", obs_t[0]); end
    peek(7'h00, "ghr_after_predict");
    checks++;
    if (obs_h[0] !== 0) begin errors++; $display("FAIL reset_ghr got %0h want 0", obs_h[0]); end
  endtask

  task automatic test_saturate();
    train(7'h05, 7'h00, 1'b1, 1'b0, "sat_up1");
    train(7'h05, 7'h00, 1'b1, 1'b0, "sat_up2");
    peek(7'h05, "sat_pred3");
    checks++;
    if (obs_t[0] !== 1'b1) begin errors++; $display("FAIL sat_at3 got %0b want 1", obs_t[0]); end
    train(7'h05, 7'h00, 1'b1, 1'b0, "sat_up3");
    train(7'h05, 7'h00, 1'b1, 1'b0, "sat_up4");
    train(7'h05, 7'h00, 1'b0, 1'b0, "sat_dn1");
    peek(7'h05, "sat_no_wrap_hi");
    checks++;
    if (obs_t[0] !== 1'b1) begin errors++; $display("FAIL sat_no_wrap_hi got %0b want 1", obs_t[0]); end
    for (int i = 0; i < 4; i++) train(7'h05, 7'h00, 1'b0, 1'b0, "sat_dn");
    train(7'h05, 7'h00, 1'b1, 1'b0, "sat_up_from0");
    peek(7'h05, "sat_no_wrap_lo");
    checks++;
    if (obs_t[0] !== 1'b0) begin errors++; $display("FAIL sat_no_wrap_lo got %0b want 0", obs_t[0]); end
    train(7'h05, 7'h00, 1'b1, 1'b0, "sat_up_to2");
    peek(7'h05, "sat_at2");
    checks++;
    if (obs_t[0] !== 1'b1) begin errors++; $display("FAIL sat_at2 got %0b want 1", obs_t[0]); end
  endtask

  task automatic test_recovery();
    train(7'h20, 7'h00, 1'b1, 1'b0, "rec_seed1");
    train(7'h20, 7'h00, 1'b1, 1'b0, "rec_seed2");
    train(7'h40, 7'h02, 1'b1, 1'b1, "rec_set_ghr05");
    step(1'b1, 7'h25, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, "rec_shift");
    checks++;
    if (obs_t[0] !== 1'b1 || obs_h[0] !== 'h05) begin
      errors++;
      $display("FAIL rec_shift got t=%0b h=%0h want t=1 h=05", obs_t[0], obs_h[0]);
    end
    step(1'b1, 7'h25, 1'b1, 1'b0, 1'b1, 7'h10, 7'h50, "rec_collide");
    checks++;
    if (obs_h[0] !== 'h0B) begin errors++; $display("FAIL rec_ghr_0b got %0h want 0b", obs_h[0]); end
    peek(7'h00, "rec_after");
    checks++;
    if (obs_h[0] !== 'h20) begin errors++; $display("FAIL rec_wins got %0h want 20", obs_h[0]); end
  endtask

  task automatic test_collision();
    logic [6:0] pc;
    train(7'h60, 7'h00, 1'b0, 1'b1, "col_clear_ghr");
    step(1'b1, 7'h03, 1'b1, 1'b1, 1'b0, 7'h00, 7'h03, "col_same_idx");
    checks++;
`ifdef GSHARE_TRAIN_FWD_EN
    if (obs_t[0] !== 1'b1) begin errors++; $display("FAIL col_fwd got %0b want 1", obs_t[0]); end
    pc = 7'h02;
`else
    if (obs_t[0] !== 1'b0) begin errors++; $display("FAIL col_nofwd got %0b want 0", obs_t[0]); end
    pc = 7'h03;
`endif
    peek(pc, "col_after");
    checks++;
    if (obs_t[0] !== 1'b1) begin errors++; $display("FAIL col_updated got %0b want 1", obs_t[0]); end
  endtask

  task automatic test_async_reset();
    train(7'h70, 7'h2A, 1'b1, 1'b1, "ar_set_ghr55");
    peek(7'h75, "ar_pre");
    checks++;
    if (obs_h[0] !== 'h55 || obs_t[0] !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got t=%0b h=%0h want t=1 h=55", obs_t[0], obs_h[0]);
    end
    pv = 1'b0; tv = 1'b0; ppc = 7'h20;
    #2 areset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ph7 !== 7'h00 || pt7 !== 1'b0 || ph4 !== 4'h0 || pt4 !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate got t7=%0b h7=%0h t4=%0b h4=%0h want all 0", pt7, ph7, pt4, ph4);
    end
    step(1'b1, 7'h20, 1'b1, 1'b1, 1'b1, 7'h7F, 7'h20, "ar_held");
    areset_n = 1'b1;
    peek(7'h20, "ar_released");
    checks++;
    if (obs_t[0] !== 1'b0 || obs_h[0] !== 0) begin
      errors++;
      $display("FAIL ar_released got t=%0b h=%0h want t=0 h=0", obs_t[0], obs_h[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++)
      step(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           7'($urandom), 7'($urandom_range(0, 15)), "random");
  endtask

  initial begin
    areset_n = 1'b0;
    pv = 1'b0; tv = 1'b0; tt = 1'b0; tm = 1'b0;
    ppc = '0; th = '0; tpc = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_saturate();
    test_recovery();
    test_collision();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
